sel4_scan_ctrl: RTL and testbench
=================================

Name: sel4_scan_ctrl

Overview:
- Upstream sequencer for the 4-to-1 selector (three cascaded 2-to-1 stages, final stage steered by sel1 XOR sel2).
- Drives sel1/sel2 to step the selector through channels 0..3 and waits a programmable settle time on each channel.
- Samples the selector output once per channel and packs the four samples into a 4-bit frame.
- Presents the frame to the downstream consumer with a valid/ready handshake; single-shot or continuous scanning.

Parameters:
- DWELL, 2, settle cycles per channel before sampling; legal range 1..15.
- CW, 4, width of the dwell counter; must hold DWELL-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  begin a scan; sampled in IDLE only.
- cont  input  1  1 = rescan automatically after each frame handshake; sampled at handshake.
- mux_out  input  1  selector output (out1 of the 4-to-1 selector).
- sel1  output  1  selector control, first stage / XOR term.
- sel2  output  1  selector control, second stage / XOR term.
- ch  output  2  channel currently selected.
- busy  output  1  high in any state other than IDLE.
- frame  output  4  frame[k] = sample of channel k.
- frame_valid  output  1  frame is complete and stable.
- frame_ready  input  1  consumer accepts the frame.

Behaviour:
- Reset (async, immediate): state=IDLE, ch=0, cnt=0, frame=0, frame_valid=0, busy=0, sel1=0, sel2=0.
- Channel encoding, decided; combinational decode of the ch register, so no extra latency:
  - ch0 (input a): sel1=0, sel2=0.
  - ch1 (input b): sel1=1, sel2=1.
  - ch2 (input c): sel1=1, sel2=0.
  - ch3 (input d): sel1=0, sel2=1.
- In IDLE and VALID, sel1/sel2 follow the ch register.
- States IDLE, SETTLE, SAMPLE, VALID. The counter cnt is CW bits wide.
- IDLE:
  - start=1 -> SETTLE, with ch=0, cnt=0, frame=0.
  - start=0 -> remain in IDLE.
- SETTLE:
  - cnt increments each cycle.
  - cnt==DWELL-1 -> SAMPLE, cnt=0.
  - SETTLE lasts exactly DWELL cycles.
- SAMPLE (1 cycle):
  - At the edge leaving SAMPLE, frame[ch] <= mux_out.
  - ch<3: ch increments and the next state is SETTLE.
  - ch==3: next state is VALID, ch holds at 3.
- VALID:
  - frame_valid=1, and frame is held constant.
  - Handshake is frame_valid & frame_ready at a rising edge.
  - On handshake with cont=1: frame_valid drops, ch=0, cnt=0, frame=0, next state SETTLE.
  - On handshake with cont=0: frame_valid drops, ch=0, next state IDLE.
  - frame_ready=0: remain in VALID indefinitely (backpressure); no sample is lost or overwritten.
- Latency: frame_valid rises exactly 4*(DWELL+1) cycles after the edge that captured start. With DWELL=2 this is 12 cycles.
- Throughput with cont=1 and frame_ready held high: one frame per 4*(DWELL+1)+1 cycles.
- start outside IDLE is ignored and is not queued.
- start asserted in the same cycle as a handshake with cont=0: the next state is IDLE; start takes effect only when sampled in IDLE on a later edge.
- frame_ready asserted outside VALID has no effect.
- mux_out is sampled only in SAMPLE; changes during SETTLE are ignored.
- rst asserted mid-scan or in VALID: immediate return to the reset values. A partial frame is discarded and frame_valid drops combinationally with rst.
- DWELL=1: SETTLE lasts one cycle, giving a 2-cycle period per channel.

Test Plan:
- Reset mid-scan:
  - Stimulus: assert rst during SETTLE of ch2.
  - Response: busy=0, frame=0, sel1=0, sel2=0 without waiting for a clock edge; the next start rescans from ch0.
- Encoding and latency:
  - Stimulus: DWELL=2; model the selector with a=1, b=0, c=1, d=1; pulse start, frame_ready=1, cont=0.
  - Response: sel pairs 00, 11, 10, 01 each held 3 cycles; frame_valid at cycle 12; frame=4'b1101; IDLE after the handshake.
- Backpressure:
  - Stimulus: as above but frame_ready=0 for 20 cycles; toggle mux_out meanwhile.
  - Response: frame_valid stays 1 and frame stays 4'b1101 throughout; one handshake on release.
- Continuous scanning:
  - Stimulus: cont=1, frame_ready=1; inputs change to a=0, b=1, c=0, d=0 after the first frame.
  - Response: frames 4'b1101 then 4'b0010; 13-cycle period.
- Ignored start:
  - Stimulus: pulse start in SETTLE and in SAMPLE.
  - Response: no restart; ch sequence unchanged.
- Minimum dwell:
  - Stimulus: DWELL=1, a=b=c=d=1.
  - Response: frame_valid at cycle 8; frame=4'b1111.

Source files
------------

// File: rtl/sel4_scan_ctrl.sv
// sel4_scan_ctrl: scan sequencer for a 4-to-1 selector.
// It steps the selector through channels 0..3 and waits DWELL settle cycles on
// each channel. It samples the selector output once per channel and packs the
// four samples into a 4-bit frame. The frame goes downstream over a
// valid/ready handshake.
// DWELL must lie in 1..15, and CW must be wide enough to hold DWELL-1.
module sel4_scan_ctrl #(
  parameter int DWELL = 2,
  parameter int CW    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_out,
  output logic       sel1,
  output logic       sel2,
  output logic [1:0] ch,
  output logic       busy,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    VALID  = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state_reg, state_next;
  logic [1:0]    ch_reg, ch_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    frame_reg, frame_next;

  logic          handshake;
  logic          settle_done;
  logic          last_ch;

  assign handshake   = (state_reg == VALID) && frame_ready;
  assign settle_done = (cnt_reg == CNT_LAST);
  assign last_ch     = (ch_reg == 2'd3);

  // State, channel, dwell counter and frame registers; reset takes effect at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ch_reg    <= 2'd0;
      cnt_reg   <= '0;
      frame_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
      cnt_reg   <= cnt_next;
      frame_reg <= frame_next;
    end
  end

  // Next-state logic: settle, then sample each channel, then hold the frame until it is accepted
  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    cnt_next   = cnt_reg;
    frame_next = frame_reg;

    case (state_reg)
      IDLE: begin
        // A new scan always begins from channel 0 with an empty frame
        if (start) begin
          state_next = SETTLE;
          ch_next    = 2'd0;
          cnt_next   = '0;
          frame_next = 4'd0;
        end
      end

      SETTLE: begin
        // Stay here for exactly DWELL cycles, so the selector path can settle
        if (settle_done) begin
          state_next = SAMPLE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_reg + CNT_ONE;
        end
      end

      SAMPLE: begin
        // Capture the settled selector output into this channel's frame bit
        frame_next[ch_reg] = mux_out;
        if (last_ch) begin
          // ch stays at 3 while the completed frame is presented
          state_next = VALID;
        end else begin
          state_next = SETTLE;
          ch_next    = ch_reg + 2'd1;
        end
      end

      VALID: begin
        // The frame stays frozen under backpressure; only a handshake releases it
        if (frame_ready) begin
          ch_next = 2'd0;
          if (cont) begin
            state_next = SETTLE;
            cnt_next   = '0;
            frame_next = 4'd0;
          end else begin
            // Any start in this cycle is not acted on. It takes effect from IDLE on a later edge.
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
        ch_next    = 2'd0;
        cnt_next   = '0;
        frame_next = 4'd0;
      end
    endcase
  end

  // Selector steering decoded from the channel register, so there is no added latency:
  // ch0 -> 00, ch1 -> 11, ch2 -> 10, ch3 -> 01. The final selector stage uses sel1^sel2.
  always_comb begin
    sel2 = ch_reg[0];
    sel1 = ch_reg[0] ^ ch_reg[1];
  end

  // Status outputs come straight from registers. frame_valid therefore falls with rst, without a clock edge.
  always_comb begin
    ch          = ch_reg;
    frame       = frame_reg;
    busy        = (state_reg != IDLE);
    frame_valid = (state_reg == VALID);
  end

  // The handshake term is kept for readability of the VALID exit condition
  logic unused_ok;
  assign unused_ok = handshake;

endmodule

// File: tb/tb_sel4_scan_ctrl.sv
// Directed testbench for sel4_scan_ctrl.
// It drives a behavioural 4-to-1 selector model from the DUT's sel1/sel2 and
// checks the channel sequencing, latency, frame contents and handshake
// behaviour. A second instance with DWELL=1 covers the minimum dwell.
module tb_sel4_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start, start1;
  logic       cont;
  logic       frame_ready, frame_ready1;
  logic       a, b, c, d;

  logic       mux_out, mux_out1;
  logic       sel1, sel2, sel1_1, sel2_1;
  logic [1:0] ch, ch1;
  logic       busy, busy1;
  logic [3:0] frame, frame1;
  logic       frame_valid, frame_valid1;

  int checks;
  int failures;

  logic [1:0] exp_sel [4];

  sel4_scan_ctrl #(.DWELL(2), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .mux_out(mux_out),
    .sel1(sel1), .sel2(sel2), .ch(ch), .busy(busy), .frame(frame),
    .frame_valid(frame_valid), .frame_ready(frame_ready)
  );

  sel4_scan_ctrl #(.DWELL(1), .CW(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cont(1'b0), .mux_out(mux_out1),
    .sel1(sel1_1), .sel2(sel2_1), .ch(ch1), .busy(busy1), .frame(frame1),
    .frame_valid(frame_valid1), .frame_ready(frame_ready1)
  );

  // Selector model: 00->a, 11->b, 10->c, 01->d
  function automatic logic sel_model(input logic s1, input logic s2,
                                     input logic ia, input logic ib,
                                     input logic ic, input logic id);
    case ({s1, s2})
      2'b00:   return ia;
      2'b11:   return ib;
      2'b10:   return ic;
      default: return id;
    endcase
  endfunction

  assign mux_out  = sel_model(sel1, sel2, a, b, c, d);
  assign mux_out1 = sel_model(sel1_1, sel2_1, a, b, c, d);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one cycle. The function returns at the negedge right after the capturing edge (n=0).
  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || frame !== 4'd0 || frame_valid !== 1'b0 ||
        sel1 !== 1'b0 || sel2 !== 1'b0 || ch !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b frame=%b fv=%b sel=%b%b ch=%0d, required 0 0000 0 00 0",
               busy, frame, frame_valid, sel1, sel2, ch);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_encoding();
    a = 1; b = 0; c = 1; d = 1; cont = 0; frame_ready = 1;
    kick();
    for (int n = 0; n < 12; n++) begin
      if (n > 0) @(negedge clk);
      checks++;
      if ({sel1, sel2} !== exp_sel[n/3] || ch !== 2'(n/3) || frame_valid !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL encoding_cycle%0d: sel=%b%b ch=%0d fv=%b busy=%b, required sel=%b ch=%0d fv=0 busy=1",
                 n, sel1, sel2, ch, frame_valid, busy, exp_sel[n/3], n/3);
      end
    end
    @(negedge clk);
    checks++;
    if (frame_valid !== 1'b1 || frame !== 4'b1101) begin
      failures++;
      $display("FAIL latency_frame: fv=%b frame=%b at cycle 12, required fv=1 frame=1101", frame_valid, frame);
    end
    $display("encoding: frame=%b fv=%b at cycle 12", frame, frame_valid);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || frame_valid !== 1'b0 || ch !== 2'd0) begin
      failures++;
      $display("FAIL encoding_idle: busy=%b fv=%b ch=%0d, required 0 0 0", busy, frame_valid, ch);
    end
  endtask

  task automatic test_backpressure();
    a = 1; b = 0; c = 1; d = 1; cont = 0; frame_ready = 0;
    kick();
    repeat (12) @(negedge clk);
    for (int n = 0; n < 20; n++) begin
      checks++;
      if (frame_valid !== 1'b1 || frame !== 4'b1101) begin
        failures++;
        $display("FAIL backpressure_hold%0d: fv=%b frame=%b, required fv=1 frame=1101", n, frame_valid, frame);
      end
      a = ~a; b = ~b; c = ~c; d = ~d;
      @(negedge clk);
    end
    a = 1; b = 0; c = 1; d = 1;
    frame_ready = 1;
    @(negedge clk);
    checks++;
    if (frame_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release: fv=%b busy=%b, required 0 0", frame_valid, busy);
    end
    $display("backpressure: released after 20 held cycles, busy=%b", busy);
    frame_ready = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_single: busy=%b fv=%b, required 0 0", busy, frame_valid);
    end
    frame_ready = 1;
  endtask

  task automatic test_reset_mid();
    a = 1; b = 1; c = 0; d = 0; cont = 0; frame_ready = 1;
    kick();
    repeat (6) @(negedge clk);
    checks++;
    if (ch !== 2'd2 || frame !== 4'b0011 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midscan_pre: ch=%0d frame=%b busy=%b, required ch=2 frame=0011 busy=1", ch, frame, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || frame !== 4'd0 || sel1 !== 1'b0 || sel2 !== 1'b0 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL midscan_async_rst: busy=%b frame=%b sel=%b%b fv=%b, required 0 0000 00 0",
               busy, frame, sel1, sel2, frame_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    a = 0; b = 1; c = 1; d = 0;
    kick();
    checks++;
    if (ch !== 2'd0 || {sel1, sel2} !== 2'b00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midscan_restart: ch=%0d sel=%b%b busy=%b, required ch=0 sel=00 busy=1", ch, sel1, sel2, busy);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (frame_valid !== 1'b1 || frame !== 4'b0110) begin
      failures++;
      $display("FAIL midscan_rescan_frame: fv=%b frame=%b, required fv=1 frame=0110", frame_valid, frame);
    end
    $display("reset_mid: rescan frame=%b", frame);
    @(negedge clk);
  endtask

  task automatic test_continuous();
    a = 1; b = 0; c = 1; d = 1; cont = 1; frame_ready = 1;
    kick();
    repeat (12) @(negedge clk);
    checks++;
    if (frame_valid !== 1'b1 || frame !== 4'b1101) begin
      failures++;
      $display("FAIL cont_frame1: fv=%b frame=%b, required fv=1 frame=1101", frame_valid, frame);
    end
    $display("continuous: frame1=%b", frame);
    a = 0; b = 1; c = 0; d = 0;
    @(negedge clk);
    checks++;
    if (frame_valid !== 1'b0 || busy !== 1'b1 || ch !== 2'd0 || frame !== 4'd0) begin
      failures++;
      $display("FAIL cont_restart: fv=%b busy=%b ch=%0d frame=%b, required 0 1 0 0000",
               frame_valid, busy, ch, frame);
    end
    repeat (11) @(negedge clk);
    checks++;
    if (frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL cont_period_early: fv=%b at cycle 24, required 0", frame_valid);
    end
    @(negedge clk);
    checks++;
    if (frame_valid !== 1'b1 || frame !== 4'b0010) begin
      failures++;
      $display("FAIL cont_frame2: fv=%b frame=%b at cycle 25, required fv=1 frame=0010", frame_valid, frame);
    end
    $display("continuous: frame2=%b", frame);
    // start coincides with a cont=0 handshake and must not be acted on until IDLE
    cont = 0;
    start = 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle_first: busy=%b fv=%b, required 0 0", busy, frame_valid);
    end
    @(negedge clk);
    start = 0;
    checks++;
    if (busy !== 1'b1 || ch !== 2'd0) begin
      failures++;
      $display("FAIL b2b_start_later: busy=%b ch=%0d, required busy=1 ch=0", busy, ch);
    end
    begin : wait_idle
      int k;
      for (k = 0; k < 40 && busy !== 1'b0; k++) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL b2b_timeout: busy=%b after 40 cycles, required 0", busy);
      end
    end
  endtask

  task automatic test_ignored_start();
    a = 1; b = 0; c = 1; d = 1; cont = 0; frame_ready = 1;
    kick();
    for (int n = 0; n < 12; n++) begin
      if (n > 0) @(negedge clk);
      start = (n == 1 || n == 2);
      checks++;
      if (ch !== 2'(n/3) || frame_valid !== 1'b0) begin
        failures++;
        $display("FAIL ignored_start_cycle%0d: ch=%0d fv=%b, required ch=%0d fv=0", n, ch, frame_valid, n/3);
      end
    end
    start = 0;
    @(negedge clk);
    checks++;
    if (frame_valid !== 1'b1 || frame !== 4'b1101) begin
      failures++;
      $display("FAIL ignored_start_frame: fv=%b frame=%b, required fv=1 frame=1101", frame_valid, frame);
    end
    $display("ignored_start: frame=%b", frame);
    @(negedge clk);
  endtask

  task automatic test_min_dwell();
    a = 1; b = 1; c = 1; d = 1; frame_ready1 = 1;
    @(negedge clk);
    start1 = 1;
    @(posedge clk);
    @(negedge clk);
    start1 = 0;
    for (int n = 0; n < 8; n++) begin
      if (n > 0) @(negedge clk);
      checks++;
      if (ch1 !== 2'(n/2) || frame_valid1 !== 1'b0) begin
        failures++;
        $display("FAIL min_dwell_cycle%0d: ch=%0d fv=%b, required ch=%0d fv=0", n, ch1, frame_valid1, n/2);
      end
    end
    @(negedge clk);
    checks++;
    if (frame_valid1 !== 1'b1 || frame1 !== 4'b1111) begin
      failures++;
      $display("FAIL min_dwell_frame: fv=%b frame=%b at cycle 8, required fv=1 frame=1111", frame_valid1, frame1);
    end
    $display("min_dwell: frame=%b", frame1);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_sel[0] = 2'b00;
    exp_sel[1] = 2'b11;
    exp_sel[2] = 2'b10;
    exp_sel[3] = 2'b01;
    start = 0; start1 = 0; cont = 0; frame_ready = 0; frame_ready1 = 0;
    a = 0; b = 0; c = 0; d = 0;
    rst = 1;

    test_reset();
    test_encoding();
    test_backpressure();
    test_reset_mid();
    test_continuous();
    test_ignored_start();
    test_min_dwell();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
